// File: rtl/mem_block_copier.sv
// Block copy / fill engine on a tagged, fixed-latency 64-bit word memory port.
// Copies run as bursts of up to four reads buffered by tag, then the same number of writes.
module mem_block_copier #(
  parameter int TagWidth = 21
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                START,
  input  logic                FILL,
  input  logic [16:0]         SRC,
  input  logic [16:0]         DST,
  input  logic [16:0]         LEN,
  input  logic [63:0]         PATTERN,
  output logic                BUSY,
  output logic                DONE,
  output logic                ACT,
  output logic                CMD,
  output logic [16:0]         ADDR,
  output logic [7:0]          BE,
  output logic [63:0]         DO,
  output logic [TagWidth-1:0] TO,
  input  logic                DRDY,
  input  logic [63:0]         DI,
  input  logic [TagWidth-1:0] TI
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_FILLW = 3'd4;
  localparam logic [2:0] S_FIN   = 3'd5;

  logic [2:0]  state;
  logic [16:0] src_ptr;
  logic [16:0] dst_ptr;
  logic [16:0] remaining;
  logic [2:0]  burst;
  logic [2:0]  idx;
  logic [63:0] pattern;
  logic [63:0] buffer [4];

  logic        capture;
  logic [1:0]  wr_slot;
  logic [63:0] wr_data;
  logic        unused_ti;

  assign unused_ti = ^TI;
  assign capture   = DRDY && (state == S_READ || state == S_WAIT);

  function automatic logic [2:0] burst_len(input logic [16:0] words);
    return (words > 17'd4) ? 3'd4 : words[2:0];
  endfunction

  // Outputs are registered, so the first write of a burst is launched in the
  // same edge that captures the last read; forward DI when its tag matches.
  always_comb begin
    wr_slot = (state == S_WAIT) ? 2'd0 : idx[1:0];
    wr_data = buffer[wr_slot];
    if (capture && TI[1:0] == wr_slot) wr_data = DI;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= S_IDLE;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      ACT       <= 1'b0;
      CMD       <= 1'b0;
      ADDR      <= '0;
      BE        <= '1;
      DO        <= '0;
      TO        <= '0;
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remaining <= '0;
      burst     <= '0;
      idx       <= '0;
      pattern   <= '0;
      for (int unsigned i = 0; i < 4; i++) buffer[i] <= '0;
    end else begin
      ACT  <= 1'b0;
      CMD  <= 1'b0;
      ADDR <= '0;
      BE   <= '1;
      DO   <= '0;
      TO   <= '0;
      DONE <= 1'b0;
      if (capture) buffer[TI[1:0]] <= DI;

      case (state)
        S_IDLE: begin
          if (START) begin
            pattern <= PATTERN;
            dst_ptr <= DST;
            src_ptr <= SRC;
            if (LEN == '0) begin
              state <= S_FIN;
              DONE  <= 1'b1;
            end else if (FILL) begin
              state     <= S_FILLW;
              BUSY      <= 1'b1;
              ACT       <= 1'b1;
              BE        <= '0;
              ADDR      <= DST;
              DO        <= PATTERN;
              dst_ptr   <= DST + 17'd1;
              remaining <= LEN - 17'd1;
            end else begin
              state     <= S_READ;
              BUSY      <= 1'b1;
              ACT       <= 1'b1;
              CMD       <= 1'b1;
              ADDR      <= SRC;
              src_ptr   <= SRC + 17'd1;
              burst     <= burst_len(LEN);
              remaining <= LEN - 17'(burst_len(LEN));
              idx       <= 3'd1;
            end
          end
        end

        S_READ: begin
          if (idx == burst) begin
            state <= S_WAIT;
          end else begin
            ACT     <= 1'b1;
            CMD     <= 1'b1;
            ADDR    <= src_ptr;
            TO      <= TagWidth'(idx[1:0]);
            src_ptr <= src_ptr + 17'd1;
            idx     <= idx + 3'd1;
          end
        end

        S_WAIT: begin
          state   <= S_WRITE;
          ACT     <= 1'b1;
          BE      <= '0;
          ADDR    <= dst_ptr;
          DO      <= wr_data;
          dst_ptr <= dst_ptr + 17'd1;
          idx     <= 3'd1;
        end

        S_WRITE: begin
          if (idx != burst) begin
            ACT     <= 1'b1;
            BE      <= '0;
            ADDR    <= dst_ptr;
            DO      <= wr_data;
            dst_ptr <= dst_ptr + 17'd1;
            idx     <= idx + 3'd1;
          end else if (remaining != '0) begin
            state     <= S_READ;
            ACT       <= 1'b1;
            CMD       <= 1'b1;
            ADDR      <= src_ptr;
            src_ptr   <= src_ptr + 17'd1;
            burst     <= burst_len(remaining);
            remaining <= remaining - 17'(burst_len(remaining));
            idx       <= 3'd1;
          end else begin
            state <= S_FIN;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
          end
        end

        S_FILLW: begin
          if (remaining == '0) begin
            state <= S_FIN;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
          end else begin
            ACT       <= 1'b1;
            BE        <= '0;
            ADDR      <= dst_ptr;
            DO        <= pattern;
            dst_ptr   <= dst_ptr + 17'd1;
            remaining <= remaining - 17'd1;
          end
        end

        S_FIN: begin
          state <= S_IDLE;
          BUSY  <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_block_copier.sv
// Scoreboard bench for mem_block_copier: a one-cycle-latency memory model plus
// a queue of expected requests (cycle, kind, address, data, tag) per job.
module tb_mem_block_copier;

  localparam int TW = 21;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          START = 1'b0;
  logic          FILL = 1'b0;
  logic [16:0]   SRC = '0;
  logic [16:0]   DST = '0;
  logic [16:0]   LEN = '0;
  logic [63:0]   PATTERN = '0;
  logic          BUSY, DONE, ACT, CMD;
  logic [16:0]   ADDR;
  logic [7:0]    BE;
  logic [63:0]   DO;
  logic [TW-1:0] TO;
  logic          DRDY = 1'b0;
  logic [63:0]   DI = '0;
  logic [TW-1:0] TI = '0;

  mem_block_copier #(.TagWidth(TW)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .FILL(FILL),
    .SRC(SRC), .DST(DST), .LEN(LEN), .PATTERN(PATTERN),
    .BUSY(BUSY), .DONE(DONE), .ACT(ACT), .CMD(CMD), .ADDR(ADDR),
    .BE(BE), .DO(DO), .TO(TO), .DRDY(DRDY), .DI(DI), .TI(TI)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          cyc;
    logic        cmd;
    logic [16:0] addr;
    logic [63:0] data;
    logic [TW-1:0] tag;
  } req_t;

  req_t        sbq[$];
  logic [63:0] mem [logic [16:0]];
  int          checks = 0;
  int          failures = 0;
  int          ncyc = 0;
  int          start_cyc = 0;
  int          exp_done = 0;
  int          job_len = 0;
  bit          job_open = 1'b0;
  bit          saw_write = 1'b0;
  bit          rd_pend = 1'b0;
  logic [16:0] rd_addr;
  logic [TW-1:0] rd_tag;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] memrd(input logic [16:0] a);
    if (mem.exists(a)) return mem[a];
    return {32'(a) * 32'h9E3779B1, 32'hA5000000 ^ 32'(a)};
  endfunction

  // Memory model: data for a read seen in cycle k is presented in cycle k+1.
  always @(posedge CLK) begin
    #1;
    DRDY = rd_pend;
    DI   = rd_pend ? memrd(rd_addr) : '0;
    TI   = rd_pend ? rd_tag : '0;
    rd_pend = 1'b0;
  end

  always @(negedge CLK) begin
    int   rel;
    req_t e;
    bit   exp_busy;
    rel = ncyc - start_cyc;
    if (ACT) begin
      if (sbq.size() == 0) begin
        check("spurious_act", 1, 0);
      end else begin
        e = sbq.pop_front();
        check("req_cyc", rel, e.cyc);
        check("req_cmd", CMD, e.cmd);
        check("req_addr", ADDR, e.addr);
        check("req_tag", TO, e.tag);
        if (!e.cmd) begin
          check("wr_be", BE, 8'h00);
          check("wr_data", DO, e.data);
        end
      end
      if (CMD) begin
        rd_pend = 1'b1;
        rd_addr = ADDR;
        rd_tag  = TO;
      end else begin
        mem[ADDR] = DO;
        saw_write = 1'b1;
      end
    end else begin
      check("idle_outs", {CMD, ADDR, BE, DO, |TO}, {1'b0, 17'h0, 8'hFF, 64'h0, 1'b0});
    end
    exp_busy = job_open && job_len != 0 && rel >= 1 && rel < exp_done;
    check("busy", BUSY, exp_busy);
    if (job_open) begin
      check("done", DONE, rel == exp_done);
      if (DONE || rel >= exp_done) begin
        check("sb_empty", sbq.size(), 0);
        job_open = 1'b0;
      end
    end else begin
      check("done_idle", DONE, 0);
    end
    ncyc++;
  end

  task automatic start_job(input bit fill, input logic [16:0] src, input logic [16:0] dst,
                           input int len, input logic [63:0] pat);
    int          c;
    int          rem;
    int          n;
    logic [16:0] s;
    logic [16:0] d;
    @(posedge CLK);
    #1;
    c = 1; rem = len; s = src; d = dst;
    if (fill) begin
      for (int i = 0; i < len; i++) begin
        sbq.push_back('{c, 1'b0, d, pat, '0});
        d = d + 17'd1;
        c++;
      end
    end else begin
      while (rem > 0) begin
        n = (rem > 4) ? 4 : rem;
        for (int i = 0; i < n; i++) begin
          sbq.push_back('{c, 1'b1, s + 17'(i), 64'h0, TW'(i)});
          c++;
        end
        c++;
        for (int i = 0; i < n; i++) begin
          sbq.push_back('{c, 1'b0, d, memrd(s + 17'(i)), '0});
          d = d + 17'd1;
          c++;
        end
        s = s + 17'(n);
        rem -= n;
      end
    end
    exp_done  = c;
    job_len   = len;
    start_cyc = ncyc;
    job_open  = 1'b1;
    saw_write = 1'b0;
    START = 1'b1; FILL = fill; SRC = src; DST = dst; LEN = 17'(len); PATTERN = pat;
    @(posedge CLK);
    #1;
    START = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300 && job_open; i++) @(posedge CLK);
    if (job_open) begin
      check("job_timeout", 1, 0);
      job_open = 1'b0;
      sbq.delete();
    end
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_state", {BUSY, DONE, ACT, CMD, ADDR, BE, DO, TO},
          {1'b0, 1'b0, 1'b0, 1'b0, 17'h0, 8'hFF, 64'h0, {TW{1'b0}}});
    @(posedge CLK);
    #1;
    RESET = 1'b0;

    start_job(1'b0, 17'h00010, 17'h00100, 1, '0);
    wait_done();
    check("len1_done_cyc", exp_done, 4);

    start_job(1'b0, 17'h00200, 17'h00400, 6, '0);
    repeat (3) @(posedge CLK);
    #1;
    START = 1'b1; FILL = 1'b1; DST = 17'h00050; LEN = 17'd3; PATTERN = 64'hDEAD;
    @(posedge CLK);
    #1;
    START = 1'b0;
    wait_done();
    for (int i = 0; i < 6; i++)
      check("copy_mem", memrd(17'h00400 + 17'(i)), memrd(17'h00200 + 17'(i)));
    check("busy_start_ignored", mem.exists(17'h00050), 0);

    start_job(1'b1, 17'h0, 17'h1FFFE, 3, 64'hA5A5A5A5A5A5A5A5);
    wait_done();
    check("fill_wrap", memrd(17'h00000), 64'hA5A5A5A5A5A5A5A5);

    start_job(1'b0, 17'h00123, 17'h00456, 0, '0);
    wait_done();

    start_job(1'b0, 17'h1FFFD, 17'h00800, 5, '0);
    wait_done();

    start_job(1'b0, 17'h00300, 17'h00900, 4, '0);
    for (int i = 0; i < 50 && !saw_write; i++) begin
      @(posedge CLK);
      #1;
    end
    check("reached_write", saw_write, 1);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    job_open = 1'b0;
    sbq.delete();
    repeat (6) @(posedge CLK);
    check("reset_abandon", mem.exists(17'h00903), 0);

    start_job(1'b0, 17'h00040, 17'h00A00, 2, '0);
    wait_done();
    repeat (3) @(posedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
